// File: rtl/mdu.sv
// rtl/mdu.sv - MIPS EX-stage multiply/divide unit holding HI/LO with fixed multi-cycle busy.
// Optional MDU_START_BUSY_EN: o_busy also asserts combinationally in the accepted start cycle.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_mduOp,
  input  logic        i_start,
  input  logic [31:0] i_srcA,
  input  logic [31:0] i_srcB,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic [31:0] o_result
);

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MTLO  = 5'd5;
  localparam logic [4:0] OP_MTHI  = 5'd6;
  localparam logic [4:0] OP_MFLO  = 5'd7;
  localparam logic [4:0] OP_MFHI  = 5'd8;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept, finish;
  logic          is_mul, is_div;

  logic [31:0]   hi, lo;
  logic [31:0]   r_hi, r_lo;
  logic          r_upd;
  logic [31:0]   sh_hi_d, sh_lo_d;
  logic          upd_d;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  logic [63:0]   prod_s, prod_u;
  assign prod_s = {{32{i_srcA[31]}}, i_srcA} * {{32{i_srcB[31]}}, i_srcB};
  assign prod_u = {32'd0, i_srcA} * {32'd0, i_srcB};

  // One unsigned divider serves both DIV and DIVU via sign/magnitude conversion.
  logic        div_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, den, uq, ur, sq, sr;

  always_comb begin
    div_sgn = (i_mduOp == OP_DIV);
    a_neg   = div_sgn & i_srcA[31];
    b_neg   = div_sgn & i_srcB[31];
    a_mag   = a_neg ? (32'd0 - i_srcA) : i_srcA;
    b_mag   = b_neg ? (32'd0 - i_srcB) : i_srcB;
    den     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq      = a_mag / den;
    ur      = a_mag % den;
    sq      = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    sr      = a_neg ? (32'd0 - ur) : ur;
  end

  assign is_mul = (i_mduOp == OP_MULT) || (i_mduOp == OP_MULTU);
  assign is_div = (i_mduOp == OP_DIV) || (i_mduOp == OP_DIVU);

  always_comb begin
    sh_hi_d = r_hi;
    sh_lo_d = r_lo;
    upd_d   = 1'b1;
    case (i_mduOp)
      OP_MULT: begin
        sh_hi_d = prod_s[63:32];
        sh_lo_d = prod_s[31:0];
      end
      OP_MULTU: begin
        sh_hi_d = prod_u[63:32];
        sh_lo_d = prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        sh_hi_d = sr;
        sh_lo_d = sq;
        upd_d   = (i_srcB != 32'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start && (is_mul || is_div)) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
          cnt_nxt   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // MT is only honoured when idle with no start; finish and MT are therefore exclusive.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_upd <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (accept) begin
        r_hi  <= sh_hi_d;
        r_lo  <= sh_lo_d;
        r_upd <= upd_d;
      end
      if (finish) begin
        if (r_upd) begin
          hi <= r_hi;
          lo <= r_lo;
        end
      end else if (state == ST_IDLE && !i_start) begin
        if (i_mduOp == OP_MTHI) hi <= i_srcA;
        if (i_mduOp == OP_MTLO) lo <= i_srcA;
      end
    end
  end

`ifdef MDU_START_BUSY_EN
  assign o_busy = (state == ST_RUN) || (i_start && (state == ST_IDLE));
`else
  assign o_busy = (state == ST_RUN);
`endif

  assign o_hi = hi;
  assign o_lo = lo;

  always_comb begin
    o_result = 32'd0;
    if (i_mduOp == OP_MFLO) o_result = lo;
    else if (i_mduOp == OP_MFHI) o_result = hi;
  end

endmodule
